// File: rtl/wbx_pkg.sv
// wbx_pkg: shared constants and helpers for the Wishbone 1-master/N-slave
// interconnect (data/select widths, default responder data, timeout sentinel,
// slave-index width helper).
package wbx_pkg;

  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;

  localparam logic [DAT_W-1:0] UNMAPPED_DAT_DEFAULT = 32'h0000_0000;
  localparam logic [DAT_W-1:0] TIMEOUT_DAT          = 32'hDEAD_BEEF;

  // Width of the slave-index field in the master address; at least 1 bit
  // so a single-slave build still has a decodable field.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wbx_pending_tracker.sv
// wbx_pending_tracker: outstanding-request bookkeeping for the interconnect.
//   clk_i/rst_i  : bus clock, asynchronous active-high reset
//   cyc_i        : master cycle (low aborts and clears the pending count)
//   accept_i     : a request was accepted this cycle
//   ack_i        : an ack is returned to the master this cycle
//   target_i     : decoded target of the current request
//   pending_o    : accepted but not yet acked requests
//   cur_sel_o    : owner of the in-flight requests
//   timeout_o    : watchdog expiry (only with WBX_1MASTER_TIMEOUT_EN defined)
module wbx_pending_tracker
  import wbx_pkg::*;
#(
  parameter int unsigned CS_W        = 3,
  parameter int unsigned MAX_PENDING = 4,
`ifdef WBX_1MASTER_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 255,
`endif
  localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cyc_i,
  input  logic              accept_i,
  input  logic              ack_i,
  input  logic [CS_W-1:0]   target_i,
  output logic [PEND_W-1:0] pending_o,
  output logic [CS_W-1:0]   cur_sel_o
`ifdef WBX_1MASTER_TIMEOUT_EN
  ,
  output logic              timeout_o
`endif
);

  localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(MAX_PENDING);

  logic [PEND_W-1:0] pending_q, pending_d;
  logic [CS_W-1:0]   cur_sel_q, cur_sel_d;

`ifdef WBX_1MASTER_TIMEOUT_EN
  localparam int unsigned WD_NEED = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned WD_W    = (WD_NEED > 8) ? WD_NEED : 8;

  logic [WD_W-1:0] wdog_q, wdog_d;

  assign timeout_o = (wdog_q == WD_W'(TIMEOUT_CYCLES));

  // Counts only idle cycles with requests outstanding; any progress restarts it.
  always_comb begin
    wdog_d = wdog_q + WD_W'(1);
    if (!cyc_i || ack_i || accept_i || (pending_q == '0) || timeout_o) begin
      wdog_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`endif

  always_comb begin
    pending_d = pending_q;
    cur_sel_d = cur_sel_q;
    if (accept_i) begin
      cur_sel_d = target_i;
    end
    // Accept and ack in the same cycle cancel out.
    if (!cyc_i) begin
      pending_d = '0;
    end else if (accept_i && !ack_i && (pending_q != PEND_FULL)) begin
      pending_d = pending_q + PEND_W'(1);
    end else if (!accept_i && ack_i && (pending_q != '0)) begin
      pending_d = pending_q - PEND_W'(1);
    end
`ifdef WBX_1MASTER_TIMEOUT_EN
    if (timeout_o) begin
      pending_d = '0;
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= '0;
      cur_sel_q <= '0;
    end else begin
      pending_q <= pending_d;
      cur_sel_q <= cur_sel_d;
    end
  end

  assign pending_o = pending_q;
  assign cur_sel_o = cur_sel_q;

endmodule

// File: rtl/wbx_1master_nslave.sv
// wbx_1master_nslave: Wishbone B4 pipelined interconnect, one master to
// PERIPH_NUM slaves, with an internal default responder for unmapped addresses.
//   wb_clk_i/wb_rst_i       : bus clock, asynchronous active-high reset
//   wbm_*_o (inputs)        : master request (cyc/stb/we/adr/sel/dat)
//   wbm_dat_i/stall_i/ack_i : routed response back to the master
//   wbs_cyc_i/wbs_stb_i     : per-slave cycle/strobe
//   wbs_we/adr/sel/dat_i    : shared request pass-throughs
//   wbs_dat/stall/ack_o     : per-slave responses (slave k data at [k*32 +: 32])
// Optional macro WBX_1MASTER_TIMEOUT_EN adds TIMEOUT_CYCLES and a watchdog that
// terminates a silent in-flight request with ack and data 32'hDEAD_BEEF.
module wbx_1master_nslave
  import wbx_pkg::*;
#(
  parameter int unsigned      PERIPH_NUM   = 4,
  parameter int unsigned      SLAVE_ADR_W  = 4,
  parameter int unsigned      MAX_PENDING  = 4,
  parameter logic [DAT_W-1:0] UNMAPPED_DAT = UNMAPPED_DAT_DEFAULT
`ifdef WBX_1MASTER_TIMEOUT_EN
  ,
  parameter int unsigned      TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  output logic [PERIPH_NUM-1:0]       wbs_cyc_i,
  output logic [PERIPH_NUM-1:0]       wbs_stb_i,
  output logic                        wbs_we_i,
  output logic [SLAVE_ADR_W-1:0]      wbs_adr_i,
  output logic [SEL_W-1:0]            wbs_sel_i,
  output logic [DAT_W-1:0]            wbs_dat_i,
  input  logic [PERIPH_NUM*DAT_W-1:0] wbs_dat_o,
  input  logic [PERIPH_NUM-1:0]       wbs_stall_o,
  input  logic [PERIPH_NUM-1:0]       wbs_ack_o,
  input  logic                        wbm_cyc_o,
  input  logic                        wbm_stb_o,
  input  logic                        wbm_we_o,
  input  logic [31:0]                 wbm_adr_o,
  input  logic [SEL_W-1:0]            wbm_sel_o,
  input  logic [DAT_W-1:0]            wbm_dat_o,
  output logic [DAT_W-1:0]            wbm_dat_i,
  output logic                        wbm_stall_i,
  output logic                        wbm_ack_i
);

  localparam int unsigned IDX_W  = idx_w(PERIPH_NUM);
  localparam int unsigned CS_W   = $clog2(PERIPH_NUM + 1);
  localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);
  localparam int unsigned DEC_W  = SLAVE_ADR_W + IDX_W;

  localparam logic [IDX_W:0]    PERIPH_LIM = (IDX_W + 1)'(PERIPH_NUM);
  localparam logic [CS_W-1:0]   INT_SEL    = CS_W'(PERIPH_NUM);
  localparam logic [PEND_W-1:0] PEND_FULL  = PEND_W'(MAX_PENDING);

  logic [IDX_W-1:0]  idx;
  logic              mapped;
  logic [CS_W-1:0]   target;
  logic [PEND_W-1:0] pending;
  logic [CS_W-1:0]   cur_sel;
  logic              blocked;
  logic              sel_stall;
  logic              resp;
  logic [DAT_W-1:0]  resp_dat;
  logic              accepted;
  logic              int_ack_q, int_ack_d;
  logic              timeout;

  assign wbs_we_i  = wbm_we_o;
  assign wbs_adr_i = wbm_adr_o[SLAVE_ADR_W-1:0];
  assign wbs_sel_i = wbm_sel_o;
  assign wbs_dat_i = wbm_dat_o;

  // Address decode: unmapped targets resolve to the internal responder.
  always_comb begin
    idx    = wbm_adr_o[SLAVE_ADR_W +: IDX_W];
    mapped = ({1'b0, idx} < PERIPH_LIM) && ((wbm_adr_o >> DEC_W) == '0);
    target = mapped ? CS_W'(idx) : INT_SEL;
  end

  // Response select by owner; loops keep out-of-range indices from being read.
  always_comb begin
    sel_stall = 1'b0;
    resp      = (cur_sel == INT_SEL) ? int_ack_q : 1'b0;
    resp_dat  = UNMAPPED_DAT;
    for (int unsigned k = 0; k < PERIPH_NUM; k++) begin
      if (idx == IDX_W'(k)) begin
        sel_stall = wbs_stall_o[k];
      end
      if (cur_sel == CS_W'(k)) begin
        resp     = wbs_ack_o[k];
        resp_dat = wbs_dat_o[k*DAT_W +: DAT_W];
      end
    end
  end

`ifndef WBX_1MASTER_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

  // Timeout also blocks so an expiring watchdog never races a new accept.
  always_comb begin
    blocked     = ((pending != '0) && (target != cur_sel)) || (pending == PEND_FULL) || timeout;
    wbm_stall_i = wbm_cyc_o & (blocked | (mapped & sel_stall));
    accepted    = wbm_cyc_o & wbm_stb_o & ~wbm_stall_i;
    wbm_ack_i   = wbm_cyc_o & (timeout | ((pending != '0) & resp));
    wbm_dat_i   = '0;
    if (wbm_cyc_o) begin
      wbm_dat_i = timeout ? TIMEOUT_DAT : resp_dat;
    end
  end

  always_comb begin
    wbs_cyc_i = '0;
    wbs_stb_i = '0;
    for (int unsigned k = 0; k < PERIPH_NUM; k++) begin
      wbs_stb_i[k] = wbm_cyc_o & wbm_stb_o & mapped & ~blocked & (idx == IDX_W'(k));
      wbs_cyc_i[k] = wbm_cyc_o &
                     (((pending != '0) && (cur_sel == CS_W'(k))) ||
                      (wbm_stb_o && mapped && (idx == IDX_W'(k)) && !blocked));
    end
  end

  // Default responder: acks exactly one cycle after an unmapped accept.
  always_comb begin
    int_ack_d = wbm_cyc_o & accepted & ~mapped;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      int_ack_q <= 1'b0;
    end else begin
      int_ack_q <= int_ack_d;
    end
  end

  wbx_pending_tracker #(
    .CS_W          (CS_W),
    .MAX_PENDING   (MAX_PENDING)
`ifdef WBX_1MASTER_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
`endif
  ) u_tracker (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .cyc_i    (wbm_cyc_o),
    .accept_i (accepted),
    .ack_i    (wbm_ack_i),
    .target_i (target),
    .pending_o(pending),
    .cur_sel_o(cur_sel)
`ifdef WBX_1MASTER_TIMEOUT_EN
    ,
    .timeout_o(timeout)
`endif
  );

endmodule

// File: tb/tb_wbx_1master_nslave.sv
// Directed bench for wbx_1master_nslave (PERIPH_NUM=4, SLAVE_ADR_W=4,
// MAX_PENDING=4). Expected read data is queued on accept and compared when
// the interconnect returns an ack.
module tb_wbx_1master_nslave;
  import wbx_pkg::*;

  localparam int unsigned PN = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [PN-1:0]     s_cyc, s_stb;
  logic              s_we;
  logic [3:0]        s_adr;
  logic [3:0]        s_sel;
  logic [31:0]       s_wdat;
  logic [PN*32-1:0]  s_dat;
  logic [PN-1:0]     s_stall, s_ack;
  logic              m_cyc, m_stb, m_we;
  logic [31:0]       m_adr;
  logic [3:0]        m_sel;
  logic [31:0]       m_wdat;
  logic [31:0]       m_rdat;
  logic              m_stall, m_ack;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  wbx_1master_nslave #(
    .PERIPH_NUM  (PN),
    .SLAVE_ADR_W (4),
    .MAX_PENDING (4),
    .UNMAPPED_DAT(32'h0000_0000)
`ifdef WBX_1MASTER_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbs_cyc_i  (s_cyc),
    .wbs_stb_i  (s_stb),
    .wbs_we_i   (s_we),
    .wbs_adr_i  (s_adr),
    .wbs_sel_i  (s_sel),
    .wbs_dat_i  (s_wdat),
    .wbs_dat_o  (s_dat),
    .wbs_stall_o(s_stall),
    .wbs_ack_o  (s_ack),
    .wbm_cyc_o  (m_cyc),
    .wbm_stb_o  (m_stb),
    .wbm_we_o   (m_we),
    .wbm_adr_o  (m_adr),
    .wbm_sel_o  (m_sel),
    .wbm_dat_o  (m_wdat),
    .wbm_dat_i  (m_rdat),
    .wbm_stall_i(m_stall),
    .wbm_ack_i  (m_ack)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scores any ack seen before the edge, then advances one clock.
  task automatic tick();
    logic [31:0] e;
    if (m_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", {63'b0, m_ack}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("ack_data", {32'b0, m_rdat}, {32'b0, e});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_adr = '0;
    m_sel = 4'hF; m_wdat = 32'hA5A5_5A5A; s_ack = '0; s_stall = '0; s_dat = '0;
    #3;
    chk("rst_ack",     {63'b0, m_ack},   64'd0);
    chk("rst_stall",   {63'b0, m_stall}, 64'd0);
    chk("rst_scyc",    {60'b0, s_cyc},   64'd0);
    chk("rst_sstb",    {60'b0, s_stb},   64'd0);
    chk("rst_pending", {61'b0, dut.pending}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single read to slave 2
    m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h25; #1;
    chk("t1_stb",   {60'b0, s_stb}, 64'h4);
    chk("t1_scyc",  {60'b0, s_cyc}, 64'h4);
    chk("t1_adr",   {60'b0, s_adr}, 64'h5);
    chk("t1_sel",   {60'b0, s_sel}, 64'hF);
    chk("t1_wdat",  {32'b0, s_wdat}, 64'hA5A5_5A5A);
    chk("t1_stall", {63'b0, m_stall}, 64'd0);
    exp_q.push_back(32'h1234_5678);
    tick();
    m_stb = 1'b0; #1;
    chk("t1_pend1", {61'b0, dut.pending}, 64'd1);
    chk("t1_noack", {63'b0, m_ack}, 64'd0);
    tick();
    s_ack[2] = 1'b1; s_dat[64 +: 32] = 32'h1234_5678; #1;
    chk("t1_ack", {63'b0, m_ack}, 64'd1);
    tick();
    s_ack = '0; #1;
    chk("t1_pend0", {61'b0, dut.pending}, 64'd0);

    // Pipelined burst to slave 1
    m_stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_adr = 32'h10 + 32'(i); #1;
      chk("burst_stall", {63'b0, m_stall}, 64'd0);
      exp_q.push_back(32'hB000_0000 + 32'(i));
      tick();
    end
    m_adr = 32'h14; #1;
    chk("full_stall", {63'b0, m_stall}, 64'd1);
    chk("full_sstb",  {60'b0, s_stb}, 64'd0);
    chk("full_pend",  {61'b0, dut.pending}, 64'd4);
    tick();
    s_ack[1] = 1'b1; s_dat[32 +: 32] = 32'hB000_0000; #1;
    chk("full_stall_ack", {63'b0, m_stall}, 64'd1);
    chk("full_ack",       {63'b0, m_ack}, 64'd1);
    tick();
    s_ack = '0; #1;
    chk("refill_pend",  {61'b0, dut.pending}, 64'd3);
    chk("refill_stall", {63'b0, m_stall}, 64'd0);
    exp_q.push_back(32'hB000_0004);
    tick();
    chk("refill_full", {61'b0, dut.pending}, 64'd4);
    m_stb = 1'b0; s_ack[1] = 1'b1; s_dat[32 +: 32] = 32'hB000_0001; #1;
    tick();
    m_stb = 1'b1; m_adr = 32'h15; s_dat[32 +: 32] = 32'hB000_0002; #1;
    chk("accack_stall", {63'b0, m_stall}, 64'd0);
    exp_q.push_back(32'hB000_0005);
    tick();
    chk("accack_pend", {61'b0, dut.pending}, 64'd3);
    m_stb = 1'b0;
    for (int j = 3; j < 6; j++) begin
      s_dat[32 +: 32] = 32'hB000_0000 + 32'(j); #1;
      tick();
    end
    s_ack = '0; #1;
    chk("burst_pend0", {61'b0, dut.pending}, 64'd0);

    // Target switch: slave 0 must drain before slave 3 is strobed
    m_stb = 1'b1; m_adr = 32'h00; #1;
    exp_q.push_back(32'hA000_0000); tick();
    m_adr = 32'h01; #1;
    exp_q.push_back(32'hA000_0001); tick();
    m_adr = 32'h30; #1;
    chk("sw_stall", {63'b0, m_stall}, 64'd1);
    chk("sw_sstb",  {60'b0, s_stb}, 64'd0);
    chk("sw_scyc",  {60'b0, s_cyc}, 64'h1);
    tick();
    s_ack[0] = 1'b1; s_dat[0 +: 32] = 32'hA000_0000; #1;
    chk("sw_stall_ack1", {63'b0, m_stall}, 64'd1);
    tick();
    s_dat[0 +: 32] = 32'hA000_0001; #1;
    chk("sw_stall_ack2", {63'b0, m_stall}, 64'd1);
    tick();
    s_ack = '0; #1;
    chk("sw_sstb3", {60'b0, s_stb}, 64'h8);
    chk("sw_go",    {63'b0, m_stall}, 64'd0);
    exp_q.push_back(32'hC000_0000);
    tick();
    m_stb = 1'b0; s_ack[3] = 1'b1; s_dat[96 +: 32] = 32'hC000_0000; #1;
    chk("sw_ack", {63'b0, m_ack}, 64'd1);
    tick();
    s_ack = '0;
    // Slave stall passes through while the strobe stays asserted
    m_stb = 1'b1; m_adr = 32'h31; s_stall[3] = 1'b1; #1;
    chk("sstall_stall", {63'b0, m_stall}, 64'd1);
    chk("sstall_sstb",  {60'b0, s_stb}, 64'h8);
    tick();
    s_stall = '0; #1;
    exp_q.push_back(32'hC000_0001);
    tick();
    m_stb = 1'b0; s_ack[2] = 1'b1; #1;
    chk("nonowner_ack", {63'b0, m_ack}, 64'd0);
    tick();
    s_ack = '0; s_ack[3] = 1'b1; s_dat[96 +: 32] = 32'hC000_0001; #1;
    tick();
    s_ack = '0;

    // Unmapped accesses go to the default responder
    m_stb = 1'b1; m_adr = 32'h0000_0100; #1;
    chk("um_stall", {63'b0, m_stall}, 64'd0);
    chk("um_sstb",  {60'b0, s_stb}, 64'd0);
    chk("um_scyc",  {60'b0, s_cyc}, 64'd0);
    exp_q.push_back(32'h0000_0000);
    tick();
    m_stb = 1'b0; #1;
    chk("um_ack", {63'b0, m_ack}, 64'd1);
    tick();
    m_stb = 1'b1; m_we = 1'b1; m_adr = 32'h40; #1;
    chk("um2_sstb", {60'b0, s_stb}, 64'd0);
    exp_q.push_back(32'h0000_0000);
    tick();
    m_stb = 1'b0; m_we = 1'b0; #1;
    chk("um2_ack", {63'b0, m_ack}, 64'd1);
    tick();

    // Abort with 3 pending, then stray acks
    m_stb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_adr = 32'h20 + 32'(i); #1;
      chk("ab_stall", {63'b0, m_stall}, 64'd0);
      tick();
    end
    chk("ab_pend3", {61'b0, dut.pending}, 64'd3);
    m_cyc = 1'b0; m_stb = 1'b0; s_ack[2] = 1'b1; #1;
    chk("ab_scyc", {60'b0, s_cyc}, 64'd0);
    chk("ab_ack",  {63'b0, m_ack}, 64'd0);
    chk("ab_rdat", {32'b0, m_rdat}, 64'd0);
    tick();
    chk("ab_pend0", {61'b0, dut.pending}, 64'd0);
    m_cyc = 1'b1; #1;
    chk("ab_stray", {63'b0, m_ack}, 64'd0);
    tick();
    s_ack = '0;

    // Asynchronous reset mid-burst (no clock edge in between)
    m_stb = 1'b1; m_adr = 32'h30; #1; tick();
    m_adr = 32'h31; #1; tick();
    m_stb = 1'b0; #1;
    chk("rs_pend2", {61'b0, dut.pending}, 64'd2);
    #1 rst = 1'b1;
    #1;
    chk("rs_pend",   {61'b0, dut.pending}, 64'd0);
    chk("rs_cursel", {61'b0, dut.cur_sel}, 64'd0);
    chk("rs_scyc",   {60'b0, s_cyc}, 64'd0);
    tick();
    rst = 1'b0;
    tick();

`ifdef WBX_1MASTER_TIMEOUT_EN
    // Silent slave 3: watchdog terminates the request
    m_stb = 1'b1; m_adr = 32'h30; #1;
    exp_q.push_back(32'hDEAD_BEEF);
    tick();
    m_stb = 1'b0; #1;
    for (int i = 0; i < 8; i++) begin
      chk("to_wait", {63'b0, m_ack}, 64'd0);
      tick();
    end
    chk("to_ack", {63'b0, m_ack}, 64'd1);
    tick();
    chk("to_pend0", {61'b0, dut.pending}, 64'd0);
`endif

    m_cyc = 1'b0; #1;
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
